lif_array_scheduler: RTL

//  Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS

---
 rtl/lif_array_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lif_array_scheduler.sv
// Shares one leaky-integrate-and-fire update datapath across N_NEURONS neurons,
// one neuron per clock, then publishes the spike vector with a one-cycle done pulse.
module lif_array_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    localparam int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cur_we,
    input  logic [IDX_W-1:0]     cur_addr,
    input  logic [WIDTH-1:0]     cur_data,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [WIDTH-1:0]     rd_state,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes
);

    localparam logic [WIDTH-1:0] THR      = WIDTH'(THRESHOLD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [WIDTH-1:0]     mem_q [N_NEURONS];
    logic [WIDTH-1:0]     cur_q [N_NEURONS];
    logic [N_NEURONS-1:0] fire_q;
    logic [N_NEURONS-1:0] fire_next;
    logic [N_NEURONS-1:0] spikes_q;

    logic [WIDTH-1:0]     s_val;
    logic [WIDTH-1:0]     c_val;
    logic [WIDTH-1:0]     decay;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     sat;
    logic                 fire_now;
    logic                 last;

    function automatic logic [WIDTH-1:0] leak(input logic [WIDTH-1:0] s);
        return s - (s >> LEAK_SHIFT);
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] v);
        return v[WIDTH] ? {WIDTH{1'b1}} : v[WIDTH-1:0];
    endfunction

    // Update datapath for the neuron selected by idx_q
    always_comb begin
        s_val    = mem_q[idx_q];
        c_val    = cur_q[idx_q];
        decay    = leak(s_val);
        sum      = {1'b0, decay} + {1'b0, c_val};
        sat      = saturate(sum);
        fire_now = (sat >= THR);
    end

    always_comb begin
        fire_next        = fire_q;
        fire_next[idx_q] = fire_now;
    end

    assign last = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            fire_q   <= '0;
            spikes_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                idx_q <= '0;
            end else if (state_q == S_RUN) begin
                idx_q  <= idx_q + 1'b1;
                fire_q <= fire_next;
                // Last neuron's fire bit is folded in so spikes are valid while done is high
                if (last) spikes_q <= fire_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
        end else if (state_q == S_RUN) begin
            mem_q[idx_q] <= fire_now ? '0 : sat;
        end
    end

    // A write colliding with the update of the same neuron only affects the next timestep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) cur_q[i] <= '0;
        end else if (cur_we) begin
            cur_q[cur_addr] <= cur_data;
        end
    end

    assign rd_state = mem_q[rd_addr];
    assign spikes   = spikes_q;

endmodule
